// File: rtl/turf_udp_pkg.sv
// Shared definitions for the UDP TX fragment arbiter: header field positions,
// arbiter state encoding and the length-to-beat conversion.
package turf_udp_pkg;

    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_W    = 16;
    localparam int HDR_PORT_LSB = 16;
    localparam int HDR_PORT_W   = 16;
    localparam int HDR_IP_LSB   = 32;
    localparam int HDR_IP_W     = 32;

    localparam int BEATS_W   = 13;
    localparam int SRC_IDX_W = 2;
    localparam int MAX_SRC   = 4;
    localparam int GAP_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } arb_state_e;

    // Number of 8-byte beats needed to carry len bytes, rounded up.
    function automatic logic [BEATS_W-1:0] len_to_beats(input logic [HDR_LEN_W-1:0] len);
        logic [HDR_LEN_W:0] rounded;
        rounded = {1'b0, len} + 17'd7;
        return rounded[BEATS_W+2:3];
    endfunction

endpackage

// File: rtl/turf_rr_pick.sv
// Combinational round-robin picker: first requesting index after 'last', wrapping.
module turf_rr_pick
    import turf_udp_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]   req_i,
    input  logic [SRC_IDX_W-1:0] last_i,
    output logic [SRC_IDX_W-1:0] grant_o,
    output logic                 any_o
);

    logic [MAX_SRC-1:0]   req_pad_s;
    logic [SRC_IDX_W-1:0] cand_s;

    // Scan from last_i+1 through last_i, keeping the first hit.
    always_comb begin
        req_pad_s = MAX_SRC'(req_i);
        cand_s    = '0;
        grant_o   = '0;
        any_o     = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand_s = SRC_IDX_W'((int'(last_i) + i) % NUM_SRC);
            if (!any_o && req_pad_s[cand_s]) begin
                grant_o = cand_s;
                any_o   = 1'b1;
            end else begin
                any_o   = any_o;
            end
        end
    end

endmodule

// File: rtl/turf_frag_stream_arb.sv
// Fragment-granular round-robin arbiter sharing one UDP TX header/payload path
// between NUM_SRC fragment generators.
module turf_frag_stream_arb
    import turf_udp_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_SRC-1:0]      src_enable_i,
    input  logic [64*NUM_SRC-1:0]   s_hdr_tdata,
    input  logic [16*NUM_SRC-1:0]   s_hdr_tuser,
    input  logic [NUM_SRC-1:0]      s_hdr_tvalid,
    output logic [NUM_SRC-1:0]      s_hdr_tready,
    input  logic [64*NUM_SRC-1:0]   s_payload_tdata,
    input  logic [8*NUM_SRC-1:0]    s_payload_tkeep,
    input  logic [NUM_SRC-1:0]      s_payload_tuser,
    input  logic [NUM_SRC-1:0]      s_payload_tlast,
    input  logic [NUM_SRC-1:0]      s_payload_tvalid,
    output logic [NUM_SRC-1:0]      s_payload_tready,
    output logic [63:0]             m_hdr_tdata,
    output logic [15:0]             m_hdr_tuser,
    output logic                    m_hdr_tvalid,
    input  logic                    m_hdr_tready,
    output logic [63:0]             m_payload_tdata,
    output logic [7:0]              m_payload_tkeep,
    output logic                    m_payload_tuser,
    output logic                    m_payload_tlast,
    output logic                    m_payload_tvalid,
    input  logic                    m_payload_tready,
    output logic [SRC_IDX_W-1:0]    cur_src_o,
    output logic                    busy_o,
    output logic [NUM_SRC-1:0]      len_err_o
);

    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam arb_state_e       POST_FRAG = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
    localparam logic             POST_BUSY = (GAP_CYCLES != 0);

    arb_state_e           state_q;
    logic [SRC_IDX_W-1:0] winner_q;
    logic [SRC_IDX_W-1:0] last_grant_q;
    logic [BEATS_W-1:0]   beats_q;
    logic [BEATS_W-1:0]   count_q;
    logic [GAP_W-1:0]     gap_q;
    logic                 busy_q;
    logic [NUM_SRC-1:0]   len_err_q;

    logic [NUM_SRC-1:0]   req_s;
    logic [SRC_IDX_W-1:0] pick_s;
    logic                 pick_any_s;

    logic [MAX_SRC-1:0]   hdr_v_pad_s;
    logic [MAX_SRC-1:0]   pay_v_pad_s;
    logic [MAX_SRC-1:0]   pay_last_pad_s;
    logic [MAX_SRC-1:0]   pay_user_pad_s;
    logic [MAX_SRC-1:0]   hdr_rdy_pad_s;
    logic [MAX_SRC-1:0]   pay_rdy_pad_s;
    logic [MAX_SRC-1:0]   err_set_pad_s;
    logic [HDR_LEN_W-1:0] hdr_len_s;
    logic                 hdr_hs_s;
    logic                 pay_hs_s;
    logic                 cnt_end_s;

    assign req_s = s_hdr_tvalid & src_enable_i;

    turf_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req_i   (req_s),
        .last_i  (last_grant_q),
        .grant_o (pick_s),
        .any_o   (pick_any_s)
    );

    // Data path: pure mux from the granted source, no storage, so AXIS stability carries through.
    always_comb begin
        hdr_v_pad_s    = MAX_SRC'(s_hdr_tvalid);
        pay_v_pad_s    = MAX_SRC'(s_payload_tvalid);
        pay_last_pad_s = MAX_SRC'(s_payload_tlast);
        pay_user_pad_s = MAX_SRC'(s_payload_tuser);

        m_hdr_tdata      = s_hdr_tdata[64*winner_q +: 64];
        m_hdr_tuser      = s_hdr_tuser[16*winner_q +: 16];
        m_hdr_tvalid     = (state_q == ST_HDR) & hdr_v_pad_s[winner_q];
        m_payload_tdata  = s_payload_tdata[64*winner_q +: 64];
        m_payload_tkeep  = s_payload_tkeep[8*winner_q +: 8];
        m_payload_tuser  = pay_user_pad_s[winner_q];
        m_payload_tvalid = (state_q == ST_PAYLOAD) & pay_v_pad_s[winner_q];

        // Non-final fragments carry no tlast, so the beat count closes them.
        cnt_end_s       = (count_q == (beats_q - 13'd1));
        m_payload_tlast = cnt_end_s | pay_last_pad_s[winner_q];

        hdr_len_s = m_hdr_tdata[HDR_LEN_LSB +: HDR_LEN_W];
        hdr_hs_s  = m_hdr_tvalid & m_hdr_tready;
        pay_hs_s  = m_payload_tvalid & m_payload_tready;

        hdr_rdy_pad_s = '0;
        pay_rdy_pad_s = '0;
        err_set_pad_s = '0;
        if (state_q == ST_HDR) begin
            hdr_rdy_pad_s[winner_q] = m_hdr_tready;
        end else begin
            hdr_rdy_pad_s = '0;
        end
        if (state_q == ST_PAYLOAD) begin
            pay_rdy_pad_s[winner_q] = m_payload_tready;
        end else begin
            pay_rdy_pad_s = '0;
        end
        if (pay_last_pad_s[winner_q] && !cnt_end_s) begin
            err_set_pad_s[winner_q] = 1'b1;
        end else begin
            err_set_pad_s = '0;
        end

        s_hdr_tready     = hdr_rdy_pad_s[NUM_SRC-1:0];
        s_payload_tready = pay_rdy_pad_s[NUM_SRC-1:0];
    end

    // Arbitration FSM and all registered status outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            winner_q     <= '0;
            last_grant_q <= SRC_IDX_W'(NUM_SRC - 1);
            beats_q      <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            busy_q       <= 1'b0;
            len_err_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        winner_q <= pick_s;
                        state_q  <= ST_HDR;
                        busy_q   <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (hdr_hs_s) begin
                        beats_q <= len_to_beats(hdr_len_s);
                        count_q <= '0;
                        if (hdr_len_s == 16'd0) begin
                            last_grant_q <= winner_q;
                            state_q      <= POST_FRAG;
                            busy_q       <= POST_BUSY;
                            gap_q        <= GAP_LOAD;
                        end else begin
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_hs_s) begin
                        count_q <= count_q + 13'd1;
                        if (m_payload_tlast) begin
                            len_err_q    <= len_err_q | err_set_pad_s[NUM_SRC-1:0];
                            last_grant_q <= winner_q;
                            state_q      <= POST_FRAG;
                            busy_q       <= POST_BUSY;
                            gap_q        <= GAP_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == 4'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cur_src_o = winner_q;
    assign busy_o    = busy_q;
    assign len_err_o = len_err_q;

endmodule

// File: tb/tb_turf_frag_stream_arb.sv
// Scoreboard bench for turf_frag_stream_arb: per-source drivers, expected beats
// queued at stimulus time, monitor pops and compares on every output handshake.
module tb_turf_frag_stream_arb;

    localparam int NS = 4;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NS-1:0]     src_enable_i;
    logic [64*NS-1:0]  s_hdr_tdata;
    logic [16*NS-1:0]  s_hdr_tuser;
    logic [NS-1:0]     s_hdr_tvalid, s_hdr_tready;
    logic [64*NS-1:0]  s_payload_tdata;
    logic [8*NS-1:0]   s_payload_tkeep;
    logic [NS-1:0]     s_payload_tuser, s_payload_tlast, s_payload_tvalid, s_payload_tready;
    logic [63:0]       m_hdr_tdata;
    logic [15:0]       m_hdr_tuser;
    logic              m_hdr_tvalid, m_hdr_tready;
    logic [63:0]       m_payload_tdata;
    logic [7:0]        m_payload_tkeep;
    logic              m_payload_tuser, m_payload_tlast, m_payload_tvalid, m_payload_tready;
    logic [1:0]        cur_src_o;
    logic              busy_o;
    logic [NS-1:0]     len_err_o;

    turf_frag_stream_arb #(.NUM_SRC(NS), .GAP_CYCLES(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .src_enable_i(src_enable_i),
        .s_hdr_tdata(s_hdr_tdata), .s_hdr_tuser(s_hdr_tuser),
        .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_tready(s_hdr_tready),
        .s_payload_tdata(s_payload_tdata), .s_payload_tkeep(s_payload_tkeep),
        .s_payload_tuser(s_payload_tuser), .s_payload_tlast(s_payload_tlast),
        .s_payload_tvalid(s_payload_tvalid), .s_payload_tready(s_payload_tready),
        .m_hdr_tdata(m_hdr_tdata), .m_hdr_tuser(m_hdr_tuser),
        .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_tready(m_hdr_tready),
        .m_payload_tdata(m_payload_tdata), .m_payload_tkeep(m_payload_tkeep),
        .m_payload_tuser(m_payload_tuser), .m_payload_tlast(m_payload_tlast),
        .m_payload_tvalid(m_payload_tvalid), .m_payload_tready(m_payload_tready),
        .cur_src_o(cur_src_o), .busy_o(busy_o), .len_err_o(len_err_o)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] hdr;
        logic [15:0] uport;
        int          nsend;
        int          tlast_beat;
        logic [7:0]  last_keep;
        logic [31:0] tag;
    } frag_t;

    typedef struct {
        logic [63:0] data;
        logic [15:0] user;
        int          src;
    } hexp_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } pexp_t;

    frag_t srcq [NS][$];
    hexp_t hq[$];
    pexp_t pq[$];

    frag_t cur [NS];
    bit    act [NS];
    bit    hdone [NS];
    int    beat [NS];

    int total = 0;
    int bad = 0;
    int pay_hs_cnt = 0;
    int frag_id = 0;
    bit toggle_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act_v, exp_v);
        end
    endtask

    task automatic push_frag(input int s, input logic [15:0] len, input int nsend,
                             input int tlb, input logic [7:0] lk);
        frag_t f;
        hexp_t h;
        pexp_t p;
        frag_id++;
        f.tag        = {8'(s), 8'(frag_id), 16'h5A00};
        f.hdr        = {8'd10, 8'd0, 8'(s), 8'(frag_id), 16'd4000 + 16'(s), len};
        f.uport      = 16'd1000 + 16'(frag_id);
        f.nsend      = nsend;
        f.tlast_beat = tlb;
        f.last_keep  = lk;
        srcq[s].push_back(f);
        h.data = f.hdr;
        h.user = f.uport;
        h.src  = s;
        hq.push_back(h);
        for (int b = 0; b < nsend; b++) begin
            p.data = {f.tag, 32'(b)};
            p.keep = (b == nsend - 1) ? lk : 8'hFF;
            p.last = (b == nsend - 1);
            p.user = (b == 0);
            pq.push_back(p);
        end
    endtask

    task automatic wait_idle(input string tag);
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < 2000) begin
            @(negedge aclk);
            n++;
            done = (hq.size() == 0) && (pq.size() == 0) && (busy_o === 1'b0) &&
                   !act[0] && !act[1] && !act[2] && !act[3];
        end
        repeat (3) @(negedge aclk);
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: hdr left %0d, payload left %0d, required 0", tag, hq.size(), pq.size());
        end
    endtask

    // Source drivers: sample handshakes at negedge, advance after the posedge.
    initial begin
        bit hh [NS];
        bit ph [NS];
        bit pv;
        s_hdr_tdata = '0; s_hdr_tuser = '0; s_hdr_tvalid = '0;
        s_payload_tdata = '0; s_payload_tkeep = '0; s_payload_tuser = '0;
        s_payload_tlast = '0; s_payload_tvalid = '0;
        m_payload_tready = 1'b1;
        for (int s = 0; s < NS; s++) begin
            act[s] = 1'b0; hdone[s] = 1'b0; beat[s] = 0;
        end
        forever begin
            @(negedge aclk);
            for (int s = 0; s < NS; s++) begin
                hh[s] = (s_hdr_tvalid[s] & s_hdr_tready[s]) === 1'b1;
                ph[s] = (s_payload_tvalid[s] & s_payload_tready[s]) === 1'b1;
            end
            @(posedge aclk);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (!aresetn) begin
                    act[s] = 1'b0;
                    srcq[s].delete();
                end else begin
                    if (act[s] && hh[s]) hdone[s] = 1'b1;
                    if (act[s] && ph[s]) beat[s]++;
                    if (act[s] && hdone[s] && beat[s] >= cur[s].nsend) act[s] = 1'b0;
                    if (!act[s] && srcq[s].size() > 0) begin
                        cur[s]   = srcq[s].pop_front();
                        act[s]   = 1'b1;
                        hdone[s] = 1'b0;
                        beat[s]  = 0;
                    end
                end
                pv = act[s] && (beat[s] < cur[s].nsend);
                s_hdr_tvalid[s]              = act[s] && !hdone[s];
                s_hdr_tdata[s*64 +: 64]      = act[s] ? cur[s].hdr : 64'd0;
                s_hdr_tuser[s*16 +: 16]      = act[s] ? cur[s].uport : 16'd0;
                s_payload_tvalid[s]          = pv;
                s_payload_tdata[s*64 +: 64]  = pv ? {cur[s].tag, 32'(beat[s])} : 64'd0;
                s_payload_tkeep[s*8 +: 8]    = (pv && beat[s] == cur[s].nsend - 1) ? cur[s].last_keep : 8'hFF;
                s_payload_tlast[s]           = pv && (beat[s] == cur[s].tlast_beat);
                s_payload_tuser[s]           = pv && (beat[s] == 0);
            end
            m_payload_tready = toggle_mode ? ~m_payload_tready : 1'b1;
        end
    end

    // Monitor: pop and compare on each output handshake; measure post-fragment gap.
    initial begin
        hexp_t he;
        pexp_t pe;
        bit    in_gap = 1'b0;
        int    gap_cnt = 0;
        forever begin
            @(negedge aclk);
            if (in_gap) begin
                if (busy_o === 1'b1) begin
                    gap_cnt++;
                end else begin
                    check("gap_cycles", 64'(gap_cnt), 64'd2);
                    in_gap = 1'b0;
                end
            end
            if (m_hdr_tvalid === 1'b1 && m_hdr_tready === 1'b1) begin
                if (hq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL hdr_unexpected: got hdr %h, required none", m_hdr_tdata);
                end else begin
                    he = hq.pop_front();
                    check("hdr_tdata", m_hdr_tdata, he.data);
                    check("hdr_tuser", {48'd0, m_hdr_tuser}, {48'd0, he.user});
                    check("cur_src", 64'(cur_src_o), 64'(he.src));
                end
            end
            if (m_payload_tvalid === 1'b1 && m_payload_tready === 1'b1) begin
                pay_hs_cnt++;
                if (pq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pay_unexpected: got beat %h, required none", m_payload_tdata);
                end else begin
                    pe = pq.pop_front();
                    check("pay_tdata", m_payload_tdata, pe.data);
                    check("pay_tkeep", 64'(m_payload_tkeep), 64'(pe.keep));
                    check("pay_tlast", 64'(m_payload_tlast), 64'(pe.last));
                    check("pay_tuser", 64'(m_payload_tuser), 64'(pe.user));
                end
                if (m_payload_tlast === 1'b1) begin
                    in_gap  = 1'b1;
                    gap_cnt = 0;
                end
            end
        end
    end

    initial begin
        int base;
        int n;
        aresetn      = 1'b0;
        src_enable_i = 4'hF;
        m_hdr_tready = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_s_hdr_tready", 64'(s_hdr_tready), 64'd0);
        check("rst_s_pay_tready", 64'(s_payload_tready), 64'd0);
        check("rst_m_hdr_tvalid", 64'(m_hdr_tvalid), 64'd0);
        check("rst_m_pay_tvalid", 64'(m_payload_tvalid), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_len_err", 64'(len_err_o), 64'd0);
        aresetn = 1'b1;

        // All four request at once: grant order 0,1,2,3 then 0 again.
        push_frag(0, 16'd16, 2, -1, 8'hFF);
        push_frag(1, 16'd16, 2, -1, 8'hFF);
        push_frag(2, 16'd16, 2, -1, 8'hFF);
        push_frag(3, 16'd16, 2, -1, 8'hFF);
        push_frag(0, 16'd16, 2, -1, 8'hFF);
        wait_idle("rr");

        // Final fragment: 72 bytes -> 9 beats, source tlast on beat 9.
        push_frag(0, 16'd72, 9, 8, 8'hFF);
        wait_idle("len72");

        // 13 bytes -> 2 beats, partial keep on the last beat.
        push_frag(1, 16'd13, 2, -1, 8'h1F);
        wait_idle("len13");
        check("len_err_clean", 64'(len_err_o), 64'd0);

        // 64 bytes announced but source tlast on beat 3.
        push_frag(2, 16'd64, 3, 2, 8'hFF);
        wait_idle("early_tlast");
        check("len_err_set", 64'(len_err_o), 64'h4);

        // Output backpressure toggling on a 9-beat fragment.
        toggle_mode = 1'b1;
        base = pay_hs_cnt;
        push_frag(0, 16'd72, 9, -1, 8'hFF);
        wait_idle("toggle");
        toggle_mode = 1'b0;
        check("toggle_handshakes", 64'(pay_hs_cnt - base), 64'd9);
        check("len_err_sticky", 64'(len_err_o), 64'h4);

        // Reset in the middle of a payload.
        base = pay_hs_cnt;
        push_frag(3, 16'd72, 9, -1, 8'hFF);
        n = 0;
        while (pay_hs_cnt < base + 3 && n < 200) begin
            @(posedge aclk);
            n++;
        end
        if (pay_hs_cnt < base + 3) begin
            total++; bad++;
            $display("FAIL timeout_midreset: got %0d beats, required 3", pay_hs_cnt - base);
        end
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        check("mid_rst_m_hdr_tvalid", 64'(m_hdr_tvalid), 64'd0);
        check("mid_rst_m_pay_tvalid", 64'(m_payload_tvalid), 64'd0);
        check("mid_rst_s_hdr_tready", 64'(s_hdr_tready), 64'd0);
        check("mid_rst_s_pay_tready", 64'(s_payload_tready), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_len_err", 64'(len_err_o), 64'd0);
        hq.delete();
        pq.delete();
        aresetn = 1'b1;

        // After reset source 0 must win over source 2.
        push_frag(0, 16'd8, 1, -1, 8'hFF);
        push_frag(2, 16'd8, 1, -1, 8'hFF);
        wait_idle("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
